// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port, IF/ID latch and perf counters.
// master = fetch_stage side, slave = surrounding pipeline/memory side.
interface fetch_stage_if #(
    parameter int unsigned INST_LEN = 32
);
    logic                freeze;
    logic                branch_taken;
    logic [INST_LEN-1:0] branch_addr;
    logic [INST_LEN-1:0] imem_addr;
    logic [INST_LEN-1:0] imem_data;
    logic [INST_LEN-1:0] pc;
    logic [INST_LEN-1:0] id_pc_plus4;
    logic [INST_LEN-1:0] id_instr;
    logic                id_valid;
    logic [31:0]         fetch_cnt;
    logic [31:0]         stall_cnt;
    logic [31:0]         flush_cnt;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_addr, pc, id_pc_plus4, id_instr, id_valid,
        output fetch_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_addr, pc, id_pc_plus4, id_instr, id_valid,
        input  fetch_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, combinational instruction fetch and IF/ID pipeline latch.
// Define FETCH_PERF_CNT_EN to build the saturating fetch/stall/flush performance counters.
module fetch_stage #(
    parameter int unsigned INST_LEN = 32,
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [31:0] NOP_INST = 32'hE000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    localparam logic [INST_LEN-1:0] LastAddr = INST_LEN'(MEM_SIZE - 4);

    logic [INST_LEN-1:0] pc_q, pc_d;
    logic [INST_LEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [INST_LEN-1:0] id_instr_q, id_instr_d;
    logic                id_valid_q, id_valid_d;
    logic [INST_LEN-1:0] pc_plus4;
    logic                in_range;
    logic                load;

    assign pc_plus4 = pc_q + INST_LEN'(4);
    assign in_range = (pc_q <= LastAddr);
    assign load     = !bus.branch_taken && !bus.freeze;

    always_comb begin
        pc_d          = pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        if (bus.branch_taken) begin
            // Redirect and flush win over a concurrent freeze.
            pc_d          = {bus.branch_addr[INST_LEN-1:2], 2'b00};
            id_pc_plus4_d = '0;
            id_instr_d    = NOP_INST;
            id_valid_d    = 1'b0;
        end else if (!bus.freeze) begin
            pc_d          = pc_plus4;
            id_pc_plus4_d = pc_plus4;
            id_instr_d    = in_range ? bus.imem_data : NOP_INST;
            id_valid_d    = in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            id_pc_plus4_q <= '0;
            id_instr_q    <= NOP_INST;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_valid    = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters saturate at all-ones instead of wrapping.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load && in_range && fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (bus.freeze && !bus.branch_taken && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.branch_taken && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.fetch_cnt = '0;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized freeze/branch/reset traffic compared every cycle against a behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] Nop     = 32'hE000_0000;
    localparam logic [31:0] Garbage = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    // Memory returns junk out of range so the stage must substitute the bubble itself.
    assign bus.imem_data = (bus.imem_addr <= 32'd1020) ? mem[bus.imem_addr[9:2]] : Garbage;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: next state from the priority rules, applied at each rising edge.
    logic [31:0] m_pc, m_pc4, m_instr, m_fc, m_sc, m_bc;
    logic        m_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input bit en);
        if (!en || v == 32'hFFFF_FFFF) return v;
        return v + 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 0; m_pc4 <= 0; m_instr <= Nop; m_valid <= 0;
            m_fc <= 0; m_sc <= 0; m_bc <= 0;
        end else begin
`ifdef FETCH_PERF_CNT_EN
            m_fc <= sat_inc(m_fc, !bus.branch_taken && !bus.freeze && m_pc <= 1020);
            m_sc <= sat_inc(m_sc, bus.freeze && !bus.branch_taken);
            m_bc <= sat_inc(m_bc, bus.branch_taken);
`endif
            if (bus.branch_taken) begin
                m_pc <= bus.branch_addr & ~32'd3;
                m_pc4 <= 0; m_instr <= Nop; m_valid <= 0;
            end else if (!bus.freeze) begin
                m_pc <= m_pc + 4;
                m_pc4 <= m_pc + 4;
                m_instr <= (m_pc <= 1020) ? mem[m_pc[9:2]] : Nop;
                m_valid <= (m_pc <= 1020);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", bus.pc, m_pc);
            check("imem_addr", bus.imem_addr, m_pc);
            check("id_pc_plus4", bus.id_pc_plus4, m_pc4);
            check("id_instr", bus.id_instr, m_instr);
            check("id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
            check("fetch_cnt", bus.fetch_cnt, m_fc);
            check("stall_cnt", bus.stall_cnt, m_sc);
            check("flush_cnt", bus.flush_cnt, m_bc);
        end
    end

    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] a);
        rst = r;
        bus.freeze = f;
        bus.branch_taken = b;
        bus.branch_addr = a;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_fc, exp_sc, exp_bc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b1; bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;

        // Reset, then fetch from 0.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        check("rst pc", bus.pc, 32'd0);
        check("rst id_instr", bus.id_instr, Nop);
        check("rst id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst id_pc_plus4", bus.id_pc_plus4, 32'd0);
        step(0, 0, 0, 0);
        check("f1 id_instr", bus.id_instr, mem[0]);
        check("f1 id_pc_plus4", bus.id_pc_plus4, 32'd4);
        check("f1 id_valid", {31'd0, bus.id_valid}, 32'd1);
        step(0, 0, 0, 0);
        check("f2 pc", bus.pc, 32'd8);
        check("f2 id_instr", bus.id_instr, mem[1]);

        // Freeze holds PC and latch.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("frz pc", bus.pc, 32'd8);
        check("frz id_instr", bus.id_instr, mem[1]);
        check("frz id_pc_plus4", bus.id_pc_plus4, 32'd8);
        step(0, 0, 0, 0);
        check("rel pc", bus.pc, 32'd12);
        check("rel id_instr", bus.id_instr, mem[2]);
        check("rel id_pc_plus4", bus.id_pc_plus4, 32'd12);

        // Branch beats freeze and flushes.
        step(0, 1, 1, 32'h20);
        check("br pc", bus.pc, 32'h20);
        check("br id_instr", bus.id_instr, Nop);
        check("br id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("br id_pc_plus4", bus.id_pc_plus4, 32'd0);

        // Misaligned target, then out-of-range fetch.
        step(0, 0, 1, 32'h23);
        check("mis pc", bus.pc, 32'h20);
        step(0, 0, 1, 32'h400);
        step(0, 0, 0, 0);
        check("oor id_instr", bus.id_instr, Nop);
        check("oor id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("oor pc", bus.pc, 32'h404);

        // PC wrap at top of address space.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("wrap pc", bus.pc, 32'd0);

        // Reset during a freeze.
        step(0, 0, 1, 32'h10);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("rstfrz pc", bus.pc, 32'd0);
        check("rstfrz id_valid", {31'd0, bus.id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("rstfrz id_instr", bus.id_instr, mem[0]);

        // Counters: 5 loads, 3 freezes, 1 branch.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 32'h40);
`ifdef FETCH_PERF_CNT_EN
        exp_fc = 32'd5; exp_sc = 32'd3; exp_bc = 32'd1;
`else
        exp_fc = 32'd0; exp_sc = 32'd0; exp_bc = 32'd0;
`endif
        check("cnt fetch", bus.fetch_cnt, exp_fc);
        check("cnt stall", bus.stall_cnt, exp_sc);
        check("cnt flush", bus.flush_cnt, exp_bc);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0: tgt = $urandom;
                1: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: tgt = 32'($urandom_range(0, 1100));
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, tgt);
        end
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
